// File: rtl/sys_mem_responder.sv
// System-side main-memory responder: one request at a time, fixed read/write wait
// states, single-word or critical-word-first wrapping line-fill reads.
module sys_mem_responder #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int DEPTH_W   = 8,
  parameter int READ_LAT  = 6,
  parameter int WRITE_LAT = 3,
  parameter int BURST_LEN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sysstrobe,
  input  logic              sysrw,
  input  logic [ADDR_W-1:0] sysaddress,
  input  logic [DATA_W-1:0] sysdata_in,
  output logic [DATA_W-1:0] sysdata_out,
  output logic              sysready,
  output logic              sysbusy
);

  localparam int DEPTH = 1 << DEPTH_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BEAT = 2'd2
  } state_t;

  state_t              state_r;
  logic [3:0]          cnt_r;
  logic [2:0]          beat_r;
  logic                rw_r;
  logic [DEPTH_W-1:0]  idx_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];

  logic [1:0]          lane_s;
  logic [DEPTH_W-1:0]  rd_idx_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic                mem_we_s;
  logic                burst_done_s;
  logic                unused_addr_s;

  // Words are stored XORed with their power-up pattern, so a never-written
  // (zero-initialised) word reads back as C0DE0000 | index.
  function automatic logic [DATA_W-1:0] init_word(input logic [DEPTH_W-1:0] idx);
    init_word = DATA_W'(32'hC0DE_0000) | DATA_W'(idx);
  endfunction

  assign unused_addr_s = ^sysaddress[ADDR_W-1:DEPTH_W];

  // Beat address generation, read data decode and completion conditions.
  always_comb begin
    lane_s = idx_r[1:0] + beat_r[1:0];
    if (BURST_LEN == 4) begin
      rd_idx_s = {idx_r[DEPTH_W-1:2], lane_s};
    end else begin
      rd_idx_s = idx_r;
    end
    rd_word_s    = mem_r[rd_idx_s] ^ init_word(rd_idx_s);
    mem_we_s     = (state_r == WAIT) && (cnt_r == 4'd0) && !rw_r;
    burst_done_s = !rw_r || (beat_r == 3'(BURST_LEN));
  end

  // Storage array: committed on the edge that raises the write sysready.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[idx_r] <= wdata_r ^ init_word(idx_r);
    end
  end

  // Request FSM with registered handshake and data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      beat_r      <= 3'd0;
      rw_r        <= 1'b0;
      idx_r       <= '0;
      wdata_r     <= '0;
      sysready    <= 1'b0;
      sysbusy     <= 1'b0;
      sysdata_out <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          sysready <= 1'b0;
          if (sysstrobe) begin
            rw_r    <= sysrw;
            idx_r   <= sysaddress[DEPTH_W-1:0];
            wdata_r <= sysdata_in;
            cnt_r   <= sysrw ? 4'(READ_LAT - 1) : 4'(WRITE_LAT - 1);
            beat_r  <= 3'd0;
            sysbusy <= 1'b1;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            sysready <= 1'b1;
            state_r  <= BEAT;
            if (rw_r) begin
              sysdata_out <= rd_word_s;
              beat_r      <= 3'd1;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        BEAT: begin
          // Busy falls together with the last ready so a strobe on this edge is lost.
          if (burst_done_s) begin
            sysready <= 1'b0;
            sysbusy  <= 1'b0;
            state_r  <= IDLE;
          end else begin
            sysdata_out <= rd_word_s;
            beat_r      <= beat_r + 3'd1;
          end
        end
        default: begin
          sysready <= 1'b0;
          sysbusy  <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule
